// File: rtl/i2c_slave_reg_ctrl_if.sv
// Bus bundle between the register-file controller and its neighbours.
// Carries the byte-level I2C slave core handshake (address, start, rw, stop,
// datareceive/received, datasend/sended), the local host port
// (host_req/we/addr/wdata/rdata/ack) and the status outputs (busy, ptr).
// slave modport:  the controller's view.
// master modport: the view of whatever drives the controller (slave core + host).
interface i2c_slave_reg_ctrl_if #(
    parameter int unsigned AW = 4
);
    logic [6:0]    address;
    logic          start;
    logic          rw;
    logic          stop;
    logic [7:0]    datareceive;
    logic          received;
    logic [7:0]    datasend;
    logic          sended;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic [7:0]    host_rdata;
    logic          host_ack;
    logic          busy;
    logic [AW-1:0] ptr;

    modport slave (
        output address,
        input  start,
        input  rw,
        input  stop,
        input  datareceive,
        input  received,
        output datasend,
        input  sended,
        input  host_req,
        input  host_we,
        input  host_addr,
        input  host_wdata,
        output host_rdata,
        output host_ack,
        output busy,
        output ptr
    );

    modport master (
        input  address,
        output start,
        output rw,
        output stop,
        output datareceive,
        output received,
        input  datasend,
        output sended,
        output host_req,
        output host_we,
        output host_addr,
        output host_wdata,
        input  host_rdata,
        input  host_ack,
        input  busy,
        input  ptr
    );
endinterface

// File: rtl/i2c_slave_reg_ctrl.sv
// Pointer-addressed register bank sequenced by an I2C slave core, shared with a
// local host port. The first byte of an I2C write sets the pointer, following
// bytes are stored with auto-increment. I2C reads present reg[ptr] on datasend
// and advance the pointer on every acknowledged byte.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    i2c_slave_reg_ctrl_if.slave: slave-core handshake, host port, busy/ptr
module i2c_slave_reg_ctrl #(
    parameter logic [6:0]  DEV_ADDR = 7'h3C,
    parameter int unsigned AW       = 4
) (
    input logic                    clk,
    input logic                    reset,
    i2c_slave_reg_ctrl_if.slave    bus
);

    localparam int unsigned Depth = 2 ** AW;

    typedef enum logic [1:0] {
        StIdle,
        StPtr,
        StWr,
        StRd
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    regs_q [Depth];
    logic [7:0]    regs_d [Depth];
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] ptr_inc;
    logic [7:0]    datasend_q, datasend_d;
    logic [7:0]    host_rdata_q, host_rdata_d;
    logic          host_ack_q, host_ack_d;
    logic          busy_q, busy_d;
    logic          i2c_wr;
    logic          i2c_fetch;
    logic          host_go;

    assign bus.address    = DEV_ADDR;
    assign bus.datasend   = datasend_q;
    assign bus.host_rdata = host_rdata_q;
    assign bus.host_ack   = host_ack_q;
    assign bus.busy       = busy_q;
    assign bus.ptr        = ptr_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        regs_d       = regs_q;
        datasend_d   = datasend_q;
        host_rdata_d = host_rdata_q;
        host_ack_d   = 1'b0;
        i2c_wr       = 1'b0;
        i2c_fetch    = 1'b0;
        ptr_inc      = ptr_q + AW'(1);

        // start outranks stop; both outrank any byte event in the same cycle.
        if (bus.start) begin
            if (bus.rw) begin
                state_d    = StRd;
                i2c_fetch  = 1'b1;
                datasend_d = regs_q[ptr_q];
            end else begin
                state_d = StPtr;
            end
        end else if (bus.stop) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StPtr: begin
                    if (bus.received) begin
                        ptr_d   = bus.datareceive[AW-1:0];
                        state_d = StWr;
                    end
                end
                StWr: begin
                    if (bus.received) begin
                        i2c_wr        = 1'b1;
                        regs_d[ptr_q] = bus.datareceive;
                        ptr_d         = ptr_inc;
                    end
                end
                StRd: begin
                    if (bus.sended) begin
                        i2c_fetch  = 1'b1;
                        ptr_d      = ptr_inc;
                        datasend_d = regs_q[ptr_inc];
                    end
                end
                default: ;
            endcase
        end

        // Host gets the bank only when the I2C side leaves the slot free; the
        // host_ack_q term spaces back-to-back grants by one cycle.
        host_go = bus.host_req && !(i2c_wr || i2c_fetch) && !host_ack_q;
        if (host_go) begin
            host_ack_d = 1'b1;
            if (bus.host_we) begin
                regs_d[bus.host_addr] = bus.host_wdata;
            end else begin
                host_rdata_d = regs_q[bus.host_addr];
            end
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            regs_q       <= '{default: 8'h00};
            ptr_q        <= '0;
            datasend_q   <= 8'h00;
            host_rdata_q <= 8'h00;
            host_ack_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            regs_q       <= regs_d;
            ptr_q        <= ptr_d;
            datasend_q   <= datasend_d;
            host_rdata_q <= host_rdata_d;
            host_ack_q   <= host_ack_d;
            busy_q       <= busy_d;
        end
    end

endmodule

// File: doc/i2c_slave_reg_ctrl.md
Name: i2c_slave_reg_ctrl

Overview:
- Register-file controller that sequences the byte-level I2C slave datapath: byte in = datareceive/received, byte out = datasend/sended, plus the slave address.
- Implements a pointer-addressed register bank with auto-increment for I2C reads and writes.
- Shares the same bank with a local host port through fixed-priority arbitration.
- Sits beside the I2C slave core and replaces the ad-hoc slave driver.

Parameters:
- DEV_ADDR, 7'h3C, 7-bit I2C device address driven to the slave core.
- AW, 4, register pointer width; bank depth = 2**AW.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- address  output  7  device address to the slave core; constant DEV_ADDR
- start  input  1  one-cycle pulse: address matched on a (repeated) START
- rw  input  1  R/W bit; valid with start (1 = master reads)
- stop  input  1  one-cycle pulse: STOP detected
- datareceive  input  8  byte received from the master
- received  input  1  one-cycle pulse: datareceive valid
- datasend  output  8  byte presented for the next master read
- sended  input  1  one-cycle pulse: datasend byte shifted out and ACKed
- host_req  input  1  local access request; held until host_ack
- host_we  input  1  1 = write, 0 = read; stable while host_req
- host_addr  input  AW  local register index
- host_wdata  input  8  local write data
- host_rdata  output  8  local read data; valid with host_ack
- host_ack  output  1  one-cycle completion pulse
- busy  output  1  high while an I2C transaction is open
- ptr  output  AW  current register pointer

Behaviour:
- Reset (synchronous, active-high, clk edge): state IDLE, all registers 8'h00, ptr 0, datasend 8'h00, host_rdata 8'h00, host_ack 0, busy 0. Reset mid-transaction aborts it; later received/sended pulses are ignored until the next start.
- FSM states: IDLE, PTR, WR, RD.
  - start & !rw from any state -> PTR.
  - start & rw from any state -> RD; one cycle later datasend <= reg[ptr].
  - PTR, received -> ptr <= datareceive[AW-1:0] (upper bits ignored), then -> WR.
  - WR, received -> reg[ptr] <= datareceive, ptr <= ptr+1, stay in WR.
  - RD, sended -> ptr <= ptr+1; next cycle datasend <= reg[new ptr]. Latency from sended to new datasend: exactly 1 clk.
  - stop -> IDLE from any state; ptr is retained, so a write-pointer / restart-read sequence works.
- start and stop in the same cycle: start wins.
- received in IDLE or RD is ignored. sended in IDLE, PTR or WR is ignored.
- Pointer wraps modulo 2**AW: 4'hF + 1 = 4'h0.
- busy = (state != IDLE), registered.
- Arbitration: single bank access slot per cycle; the I2C side has absolute priority.
  - An I2C slot is a WR-state received or an RD fetch cycle (start&rw or sended).
  - Host access is performed in the first cycle with host_req=1, no I2C slot and host_ack=0.
  - host_ack pulses on the following cycle. For reads, host_rdata carries the register value at the access cycle.
  - One access per request; host deasserts or changes the request after ack. Back-to-back requests yield ack at most every other cycle.
  - Host writes do not update a datasend byte already fetched. The change is seen on the next fetch.
- address is a constant assign, not reset-dependent.

Test Plan:
- Reset then idle -> all outputs 0, address = 7'h3C, busy 0. Host read of reg 5 -> host_rdata 8'h00, host_ack one cycle after grant.
- start rw=0, bytes 8'h02, 8'hA5, 8'h5A, stop -> reg2 = A5, reg3 = 5A, ptr = 4, busy high from start to stop.
- start rw=0, byte 8'h0F, stop; start rw=1 -> datasend = reg15 after 1 clk. sended -> ptr wraps to 0, datasend = reg0 the next clk.
- Pointer byte 8'hF3 -> ptr = 3 (upper bits masked). Then received pulses in RD state or IDLE -> no register change.
- host_req write reg3 = 8'h77 held while I2C received pulses are issued in WR on consecutive cycles -> host stalls until the first cycle with no I2C slot, then writes. An I2C write of reg3 in the same window is applied first. host_ack is a single pulse.
- reset asserted between two write bytes -> state IDLE, regs 0, the following received pulse is ignored. start with stop in the same cycle -> state PTR.
